// File: rtl/can_clock_divider_if.sv
// can_clock_divider_if: control, divisor and time-base signals of the CAN clock divider.
// CAN_CLKDIV_SAMPLE_PT_EN adds the sample-point input and strobe.
interface can_clock_divider_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             load;
    logic             brs;
    logic             sync;
    logic [CNT_W-1:0] div_nom;
    logic [CNT_W-1:0] div_data;
    logic             clk_out;
    logic             tick;
    logic [CNT_W-1:0] div_act;
`ifdef CAN_CLKDIV_SAMPLE_PT_EN
    logic [CNT_W-1:0] sample_pt;
    logic             sample_tick;
`endif

    modport master (
`ifdef CAN_CLKDIV_SAMPLE_PT_EN
        output sample_pt,
        input  sample_tick,
`endif
        output en, load, brs, sync, div_nom, div_data,
        input  clk_out, tick, div_act
    );

    modport slave (
`ifdef CAN_CLKDIV_SAMPLE_PT_EN
        input  sample_pt,
        output sample_tick,
`endif
        input  en, load, brs, sync, div_nom, div_data,
        output clk_out, tick, div_act
    );
endinterface

// File: rtl/can_clock_divider.sv
// can_clock_divider: programmable CAN time base with nominal/data divisors, sync and glitch-free reload.
// Optional sample-point strobe enabled by CAN_CLKDIV_SAMPLE_PT_EN.
module can_clock_divider #(
    parameter int CNT_W        = 16,
    parameter int NOM_DIV_RST  = 40,
    parameter int DATA_DIV_RST = 10
) (
    input logic              clk_in,
    input logic              rst,
    can_clock_divider_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] p, p_nxt;
    logic [CNT_W-1:0] div_act, div_nxt;
    logic [CNT_W-1:0] nom_sh, nom_nxt, data_sh, data_nxt;
    logic [CNT_W-1:0] half;
    logic             restart;
    logic             clk_out_r, tick_r;

    // Divisors below 2 cannot form a two-phase clock, so they saturate at 2.
    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(2)) ? CNT_W'(2) : v;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A new period starts when leaving IDLE, on sync, or on the natural wrap.
    always_comb begin
        state_nxt = bus.en ? RUN : IDLE;
        nom_nxt   = bus.load ? clamp(bus.div_nom) : nom_sh;
        data_nxt  = bus.load ? clamp(bus.div_data) : data_sh;
        restart   = (state == IDLE) || bus.sync || (p == div_act - 1'b1);
        div_nxt   = (bus.en && restart) ? (bus.brs ? data_nxt : nom_nxt) : div_act;
        p_nxt     = (!bus.en || restart) ? '0 : p + 1'b1;
        half      = (div_nxt >> 1) + {{(CNT_W-1){1'b0}}, div_nxt[0]};
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            p         <= '0;
            div_act   <= clamp(CNT_W'(NOM_DIV_RST));
            nom_sh    <= clamp(CNT_W'(NOM_DIV_RST));
            data_sh   <= clamp(CNT_W'(DATA_DIV_RST));
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            p         <= p_nxt;
            div_act   <= div_nxt;
            nom_sh    <= nom_nxt;
            data_sh   <= data_nxt;
            clk_out_r <= bus.en && (p_nxt < half);
            tick_r    <= bus.en && (p_nxt == '0);
        end
    end

    assign bus.clk_out = clk_out_r;
    assign bus.tick    = tick_r;
    assign bus.div_act = div_act;

`ifdef CAN_CLKDIV_SAMPLE_PT_EN
    logic [CNT_W-1:0] spt_lim;
    logic             sample_tick_r;

    // Sample points beyond the period end fire on the last count instead.
    assign spt_lim = (bus.sample_pt < div_nxt - 1'b1) ? bus.sample_pt : div_nxt - 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst) sample_tick_r <= 1'b0;
        else     sample_tick_r <= bus.en && (p_nxt == spt_lim);
    end

    assign bus.sample_tick = sample_tick_r;
`endif
endmodule

// File: doc/can_clock_divider.md
Name: can_clock_divider

Overview:
- Runtime-programmable clock divider and time-base generator for the CAN/CAN-FD controller.
- Produces a divided clock (clk_out) and a one-cycle period strobe (tick) from clk_in.
- Holds two divisor sets, nominal (arbitration phase) and data (FD bit-rate-switch phase), selectable at period boundaries.
- Supports hard resynchronisation (sync) and glitch-free divisor reload.

Parameters:
CNT_W, 16, width of divisor and internal period counter
NOM_DIV_RST, 40, nominal divisor loaded at reset
DATA_DIV_RST, 10, data-phase divisor loaded at reset

Ports:
clk_in  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
en  input  1  run enable; 0 = hold idle
div_nom  input  CNT_W  new nominal divisor, captured on load
div_data  input  CNT_W  new data divisor, captured on load
load  input  1  one-cycle strobe; captures div_nom/div_data into shadow registers
brs  input  1  0 = use nominal divisor, 1 = use data divisor
sync  input  1  one-cycle strobe; restarts the period immediately
clk_out  output  1  divided clock
tick  output  1  one-cycle strobe at the start of each period
div_act  output  CNT_W  divisor of the period currently running

Behaviour:
- Reset (rst=1 at posedge):
  - Shadow registers = NOM_DIV_RST / DATA_DIV_RST; div_act = NOM_DIV_RST.
  - Counter p = 0; clk_out = 0; tick = 0.
  - Reset mid-period aborts the period with no partial pulse afterwards.
- Divisor clamp: any captured or active value < 2 is treated as 2. div_act shows the clamped value.
- States:
  - IDLE (en=0): p held at 0, clk_out=0, tick=0. Shadow registers still accept load.
  - RUN (en=1): IDLE->RUN on the first edge with en=1. That edge starts period 0, and p=0 is registered on it.
  - RUN->IDLE on any edge with en=0. Outputs go to 0 on that same edge, with no completion of the current period.
- Counting: in RUN, p increments each clk_in and wraps from div_act-1 to 0. Each wrap is a period boundary.
- Outputs are registered decodes of p, valid on the same edge that p is registered:
  - clk_out = 1 when p < ceil(div_act/2), else 0. D=40: 20 high / 20 low. D=3: 2 high / 1 low.
  - tick = 1 exactly when p = 0. tick coincides with the rising edge of clk_out.
- Divisor selection:
  - At each boundary, div_act <= brs ? data_shadow : nom_shadow.
  - brs or load arriving mid-period never alters the running period.
- sync (RUN only):
  - Forces p=0 on the next edge and asserts tick.
  - The new div_act is selected from the current brs and shadows, including a load presented on the same edge.
  - sync in IDLE is ignored.
- Simultaneous events:
  - rst overrides all.
  - en=0 overrides sync.
  - sync together with a natural boundary gives a single tick.
  - load with sync or boundary: the newly loaded values take effect in that new period.
- Counter width: p and comparisons use CNT_W bits. Maximum divisor is 2^CNT_W - 1, with no overflow.

Optional Feature:
- Macro: CAN_CLKDIV_SAMPLE_PT_EN.
- With the macro defined:
  - Adds input sample_pt [CNT_W] and output sample_tick [1].
  - sample_tick = 1 for one cycle when p = min(sample_pt, div_act-1), registered like tick.
  - sample_pt = 0 makes sample_tick coincide with tick.
  - sample_pt is sampled live; changes apply from the next matching count.
  - Reset value of sample_tick is 0; it is 0 in IDLE.
- Without the macro: the ports and logic are absent; the rest of the behaviour is unchanged.

Test Plan:
- Reset then en=1, defaults -> tick every 40 cycles; clk_out 20 high / 20 low; div_act=40; first tick on first enabled edge.
- load div_nom=5, div_data=2 mid-period, brs=0 -> current 40-cycle period completes; then period 5 with clk_out 3 high / 2 low; toggle brs=1 -> after the next boundary, period 2 (1 high / 1 low), div_act=2.
- load div_nom=0 and div_nom=1 -> both behave as 2; div_act reads 2.
- sync at p=17 of a 40 period -> tick and clk_out rise on the next edge, new 40-cycle period; sync landing exactly on a wrap edge -> single tick, no double pulse.
- rst asserted at p=10, then en toggled 0 for 3 cycles at p=25 -> outputs 0 immediately in both cases; restart begins at p=0 with tick.
- With CAN_CLKDIV_SAMPLE_PT_EN, D=10, sample_pt=7 -> sample_tick at p=7 every period; sample_pt=50 -> sample_tick at p=9.
